// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never below 1 so the counter always exists.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fulladd.sv
// Single-bit full adder cell: the only arithmetic in the serial adder datapath.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fulladd cell, LSB first, WIDTH cycles per addition,
// with results held in separate output registers so RUN never shows partial sums.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned      CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             fa_sum;
    logic             fa_carry;
    logic             last;

    fulladd u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Result register holds WIDTH-1 bits; the final sum bit goes straight to sum_out.
    assign res_next = {fa_sum, res_sr};
    assign last     = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            res_sr  <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_carry;
                    res_sr <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum_out <= res_next;
                        cout    <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
module tb_serial_adder;

    typedef struct {
        logic [8:0]  res;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q8[$];
    exp_t        q4[$];
    exp_t        e8, e4;
    logic [8:0]  last8 = '0;
    int unsigned busy_run8 = 0;
    int unsigned busy_run4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for the 8-bit adder: result, latency, busy length, and output hold during RUN.
    always @(negedge clk) begin
        if (done8) begin
            check("done8_excl_busy", 32'(busy8), 32'd0);
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sum8", 32'({cout8, sum8}), 32'(e8.res));
                check("latency8", cyc, e8.due);
                check("busy_len8", busy_run8, 32'd8);
                last8 = e8.res;
            end
            busy_run8 = 0;
        end else if (busy8) begin
            busy_run8++;
            check("hold8", 32'({cout8, sum8}), 32'(last8));
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            check("done4_excl_busy", 32'(busy4), 32'd0);
            if (q4.size() == 0) begin
                check("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("sum4", 32'({cout4, sum4}), 32'(e4.res));
                check("latency4", cyc, e4.due);
                check("busy_len4", busy_run4, 32'd4);
            end
            busy_run4 = 0;
        end else if (busy4) begin
            busy_run4++;
        end
    end

    // Returns right after edge E+9, so the next issue lands at the earliest legal start.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] res);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{res: res, due: cyc + 8});
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
        repeat (9) @(posedge clk);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = 5'(a) + 5'(b) + 5'(c);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        q4.push_back('{res: 9'(r), due: cyc + 4});
        @(negedge clk);
        start4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~c;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_out8", 32'({cout8, sum8}), 32'd0);
        check("rst_out4", 32'({busy4, done4, cout4, sum4}), 32'd0);
        rst = 1'b0;

        issue8(8'h00, 8'h00, 1'b0, 9'h000);
        issue8(8'hFF, 8'h01, 1'b0, 9'h100);
        issue8(8'd100, 8'd27, 1'b0, 9'h07F);
        issue8(8'hA5, 8'h5A, 1'b1, 9'h100);

        // Start pulses sampled at edges E+3 (RUN) and E+9 (DONE) must be ignored.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{res: 9'h010, due: cyc + 8});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        a8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (14) @(posedge clk);

        // Reset sampled at edge E+4 aborts the addition without a done pulse.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        q8.delete();
        last8 = '0;
        busy_run8 = 0;
        @(negedge clk);
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_out8", 32'({cout8, sum8}), 32'd0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        issue8(8'h03, 8'h04, 1'b0, 9'h007);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue4(4'(a), 4'(b), 1'(c));
                end
            end
        end

        for (int i = 0; i < 40 && (q8.size() != 0 || q4.size() != 0); i++) begin
            @(posedge clk);
        end
        check("drain8", 32'(q8.size()), 32'd0);
        check("drain4", 32'(q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
